// File: rtl/ras_ckpt.sv
// Return-address stack with checkpoint/restore of top pointer and occupancy.
// Circular entry array; push past full evicts the oldest entry.
module ras_ckpt #(
   parameter int RAS_DEPTH        = 8,
   parameter int RAS_TARGET_WIDTH = 14,
   localparam int LOG_RAS_DEPTH   = $clog2(RAS_DEPTH),
   localparam int CW              = $clog2(RAS_DEPTH + 1)
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   input  logic                        restore_valid,
   input  logic [LOG_RAS_DEPTH-1:0]    restore_index,
   input  logic [CW-1:0]               restore_count,
   output logic [RAS_TARGET_WIDTH-1:0] top_target,
   output logic                        top_valid,
   output logic [LOG_RAS_DEPTH-1:0]    ras_index,
   output logic [CW-1:0]               ras_count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam logic [LOG_RAS_DEPTH-1:0] LAST_IX  = LOG_RAS_DEPTH'(RAS_DEPTH - 1);
   localparam logic [LOG_RAS_DEPTH:0]   DEPTH_IX = (LOG_RAS_DEPTH + 1)'(RAS_DEPTH);
   localparam logic [CW-1:0]            DEPTH_C  = CW'(RAS_DEPTH);

   logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_DEPTH];
   logic [RAS_TARGET_WIDTH-1:0] entry_d [RAS_DEPTH];
   logic [LOG_RAS_DEPTH-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        overflow_q, overflow_d;
   logic                        underflow_q, underflow_d;
   logic [LOG_RAS_DEPTH-1:0]    ptr_inc, ptr_dec;

   // Explicit wrap compares keep non-power-of-two depths correct.
   function automatic logic [LOG_RAS_DEPTH-1:0] inc_ptr(input logic [LOG_RAS_DEPTH-1:0] p);
      return (p == LAST_IX) ? '0 : p + LOG_RAS_DEPTH'(1);
   endfunction

   function automatic logic [LOG_RAS_DEPTH-1:0] dec_ptr(input logic [LOG_RAS_DEPTH-1:0] p);
      return (p == '0) ? LAST_IX : p - LOG_RAS_DEPTH'(1);
   endfunction

   assign ptr_inc = inc_ptr(ptr_q);
   assign ptr_dec = dec_ptr(ptr_q);

   always_comb begin
      ptr_d       = ptr_q;
      count_d     = count_q;
      entry_d     = entry_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (restore_valid) begin
         ptr_d   = ({1'b0, restore_index} >= DEPTH_IX) ? '0 : restore_index;
         count_d = (restore_count > DEPTH_C) ? DEPTH_C : restore_count;
      end else if (push_valid && pop_valid) begin
         // Replace the top in place: the pop consumed the old top this cycle.
         entry_d[ptr_q] = push_target;
         count_d        = (count_q == '0) ? CW'(1) : count_q;
      end else if (push_valid) begin
         ptr_d            = ptr_inc;
         entry_d[ptr_inc] = push_target;
         if (count_q == DEPTH_C) overflow_d = 1'b1;
         else                    count_d    = count_q + CW'(1);
      end else if (pop_valid) begin
         if (count_q == '0) begin
            underflow_d = 1'b1;
         end else begin
            ptr_d   = ptr_dec;
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q       <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) entry_q[i] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         entry_q     <= entry_d;
      end
   end

   assign top_target = entry_q[ptr_q];
   assign top_valid  = (count_q != '0);
   assign ras_index  = ptr_q;
   assign ras_count  = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: depth-8 instance plus a depth-6 instance for wrap checks.
module tb_ras_ckpt;

   logic        CLK;
   int          checks;
   int          errors;

   // depth 8 instance
   logic        rst0, push0, pop0, rv0;
   logic [13:0] tgt0;
   logic [2:0]  ri0;
   logic [3:0]  rc0;
   logic [13:0] top0;
   logic        tv0, ovf0, unf0;
   logic [2:0]  idx0;
   logic [3:0]  cnt0;

   // depth 6 instance
   logic        rst1, push1, pop1, rv1;
   logic [13:0] tgt1;
   logic [2:0]  ri1;
   logic [2:0]  rc1;
   logic [13:0] top1;
   logic        tv1, ovf1, unf1;
   logic [2:0]  idx1;
   logic [2:0]  cnt1;

   ras_ckpt #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(14)) u0 (
      .CLK(CLK), .RST(rst0), .push_valid(push0), .push_target(tgt0), .pop_valid(pop0),
      .restore_valid(rv0), .restore_index(ri0), .restore_count(rc0),
      .top_target(top0), .top_valid(tv0), .ras_index(idx0), .ras_count(cnt0),
      .overflow(ovf0), .underflow(unf0));

   ras_ckpt #(.RAS_DEPTH(6), .RAS_TARGET_WIDTH(14)) u1 (
      .CLK(CLK), .RST(rst1), .push_valid(push1), .push_target(tgt1), .pop_valid(pop1),
      .restore_valid(rv1), .restore_index(ri1), .restore_count(rc1),
      .top_target(top1), .top_valid(tv1), .ras_index(idx1), .ras_count(cnt1),
      .overflow(ovf1), .underflow(unf1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle0();
      push0 = 1'b0; pop0 = 1'b0; rv0 = 1'b0; tgt0 = '0; ri0 = '0; rc0 = '0;
   endtask

   task automatic do_push0(input logic [13:0] t);
      push0 = 1'b1; tgt0 = t; cyc(); idle0();
   endtask

   task automatic do_pop0();
      pop0 = 1'b1; cyc(); idle0();
   endtask

   task automatic do_reset0();
      rst0 = 1'b1; cyc(); rst0 = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle0();
      rst0 = 1'b1;
      rst1 = 1'b1; push1 = 1'b0; pop1 = 1'b0; rv1 = 1'b0; tgt1 = '0; ri1 = '0; rc1 = '0;

      // Reset with a concurrent push: nothing may be written.
      push0 = 1'b1; tgt0 = 14'h3FFF;
      cyc(); cyc();
      idle0(); rst0 = 1'b0;
      chk("rst_index", idx0, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_top",   top0, 0);
      chk("rst_valid", tv0, 0);
      chk("rst_ovf",   ovf0, 0);
      chk("rst_unf",   unf0, 0);

      // Pop while empty
      do_pop0();
      chk("unf_pulse", unf0, 1);
      chk("unf_count", cnt0, 0);
      chk("unf_index", idx0, 0);
      cyc();
      chk("unf_clear", unf0, 0);

      // Basic push/pop
      do_push0(14'h0011);
      do_push0(14'h0022);
      do_push0(14'h0033);
      chk("p3_index", idx0, 3);
      chk("p3_count", cnt0, 3);
      chk("p3_top",   top0, 14'h0033);
      chk("p3_valid", tv0, 1);
      do_pop0();
      chk("pop_top",   top0, 14'h0022);
      chk("pop_count", cnt0, 2);
      chk("pop_index", idx0, 2);

      // Fill past capacity
      do_reset0();
      for (int i = 0; i < 8; i++) do_push0(14'h100 + 14'(i));
      chk("full_count", cnt0, 8);
      chk("full_ovf",   ovf0, 0);
      do_push0(14'h108);
      chk("ovf_count", cnt0, 8);
      chk("ovf_index", idx0, 1);
      chk("ovf_pulse", ovf0, 1);
      chk("ovf_top",   top0, 14'h108);
      cyc();
      chk("ovf_clear", ovf0, 0);
      for (int i = 0; i < 8; i++) begin
         chk("drain_top", top0, 14'h108 - 14'(i));
         do_pop0();
      end
      chk("drain_valid", tv0, 0);
      chk("drain_count", cnt0, 0);
      chk("drain_index", idx0, 1);
      chk("drain_unf",   unf0, 0);
      do_pop0();
      chk("unf9_pulse", unf0, 1);
      chk("unf9_index", idx0, 1);
      chk("unf9_count", cnt0, 0);
      do_pop0();
      chk("unf_b2b", unf0, 1);
      cyc();
      chk("unf_b2b_clear", unf0, 0);

      // Push+pop on empty stack yields one entry
      do_reset0();
      push0 = 1'b1; pop0 = 1'b1; tgt0 = 14'h0055; cyc(); idle0();
      chk("pp_empty_count", cnt0, 1);
      chk("pp_empty_index", idx0, 0);
      chk("pp_empty_top",   top0, 14'h0055);
      chk("pp_empty_unf",   unf0, 0);

      // Push and pop same cycle replaces top
      do_reset0();
      do_push0(14'h000A);
      do_push0(14'h000B);
      push0 = 1'b1; pop0 = 1'b1; tgt0 = 14'h000C; cyc(); idle0();
      chk("pp_top",   top0, 14'h000C);
      chk("pp_count", cnt0, 2);
      chk("pp_index", idx0, 2);
      chk("pp_ovf",   ovf0, 0);

      // Checkpoint/restore with a push that must be ignored
      do_reset0();
      do_push0(14'h000A);
      do_push0(14'h000B);
      chk("save_index", idx0, 2);
      chk("save_count", cnt0, 2);
      do_push0(14'h000D);
      do_push0(14'h000E);
      do_pop0();
      chk("pre_rest_top", top0, 14'h000D);
      rv0 = 1'b1; ri0 = 3'd2; rc0 = 4'd2; push0 = 1'b1; tgt0 = 14'h03FF;
      cyc(); idle0();
      chk("rest_index", idx0, 2);
      chk("rest_count", cnt0, 2);
      chk("rest_top",   top0, 14'h000B);
      chk("rest_ovf",   ovf0, 0);
      do_pop0();
      chk("rest_pop_top", top0, 14'h000A);
      chk("rest_pop_cnt", cnt0, 1);

      // Restore count clamp
      rv0 = 1'b1; ri0 = 3'd5; rc0 = 4'd15; pop0 = 1'b1;
      cyc(); idle0();
      chk("clamp_count", cnt0, 8);
      chk("clamp_index", idx0, 5);
      chk("clamp_unf",   unf0, 0);

      // Depth 6: out-of-range restore index and wrap
      rst1 = 1'b0;
      rv1 = 1'b1; ri1 = 3'd7; rc1 = 3'd7;
      cyc(); rv1 = 1'b0; ri1 = '0; rc1 = '0;
      chk("d6_rest_index", idx1, 0);
      chk("d6_rest_count", cnt1, 6);
      rst1 = 1'b1; cyc(); rst1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push1 = 1'b1; tgt1 = 14'h200 + 14'(i); cyc();
      end
      chk("d6_index5", idx1, 5);
      tgt1 = 14'h205; cyc();
      chk("d6_wrap0",  idx1, 0);
      chk("d6_count6", cnt1, 6);
      chk("d6_ovf0",   ovf1, 0);
      tgt1 = 14'h206; cyc();
      push1 = 1'b0;
      chk("d6_wrap1", idx1, 1);
      chk("d6_ovf1",  ovf1, 1);
      chk("d6_top",   top1, 14'h206);
      cyc();
      chk("d6_ovf_clear", ovf1, 0);
      chk("d6_count_hold", cnt1, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
